thread_lane_router: RTL



---
 rtl/thread_lane_router_if.sv | 37 +++
 rtl/thread_lane_router.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/thread_lane_router_if.sv
`default_nettype none
// ============================================================================
//  Module   : thread_lane_router_if
//  Brief    : Lane-side candidate/ack and output-FIFO pop bundle for the
//             thread lane router.
//  Revision : 1.0 - initial release
// ============================================================================
interface thread_lane_router_if #(
    parameter int NUM_LANES  = 4,
    parameter int TID_W      = 8,
    parameter int CHUNK_W    = 2,
    parameter int FIFO_DEPTH = 2
);
    localparam int c_ft = CHUNK_W + TID_W;
    localparam int c_cw = $clog2(FIFO_DEPTH + 1);

    logic [NUM_LANES*TID_W-1:0]  next_tid;
    logic [NUM_LANES-1:0]        lane_valid;
    logic [NUM_LANES-1:0]        lane_ack;
    logic [NUM_LANES-1:0]        out_pop;
    logic [NUM_LANES*2*c_ft-1:0] out_data;
    logic [NUM_LANES-1:0]        out_valid;
    logic [NUM_LANES*c_cw-1:0]   out_count;

    // Lane sources and output consumers
    modport master (
        output next_tid, lane_valid, out_pop,
        input  lane_ack, out_data, out_valid, out_count
    );

    // Router
    modport slave (
        input  next_tid, lane_valid, out_pop,
        output lane_ack, out_data, out_valid, out_count
    );
endinterface
`default_nettype wire

// File: rtl/thread_lane_router.sv
`default_nettype none
// ============================================================================
//  Module   : thread_lane_router
//  Brief    : Maps source lanes onto output channels by unrolling factor,
//             round-robin arbitrates per channel, buffers winners in FIFOs.
//  Revision : 1.0 - initial release
// ============================================================================
module thread_lane_router #(
    parameter int NUM_LANES   = 4,
    parameter int TID_W       = 8,
    parameter int CHUNK_W     = 2,
    parameter int FIFO_DEPTH  = 2,
    parameter int LANE_STRIDE = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(NUM_LANES):0]   unroll_log2,
    input  logic [CHUNK_W-1:0]           chunk_base_addr,
    input  logic                         flush,
    thread_lane_router_if.slave          bus
);
    localparam int c_log2n = $clog2(NUM_LANES);
    localparam int c_uw    = c_log2n + 1;
    localparam int c_ft    = CHUNK_W + TID_W;
    localparam int c_cw    = $clog2(FIFO_DEPTH + 1);
    localparam int c_aw    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [c_uw-1:0]     r_mode;
    logic                w_mode_chg;
    logic                w_legal;
    logic [c_uw-1:0]     w_u_cnt;
    logic [c_uw-1:0]     w_grp_cnt;
    logic [c_log2n-1:0]  w_g_mask;
    logic [TID_W-1:0]    w_tid      [NUM_LANES];
    logic [NUM_LANES-1:0] w_ack_each [NUM_LANES];
    logic [2*c_ft-1:0]   w_data_each [NUM_LANES];
    logic [c_cw-1:0]     w_cnt_each  [NUM_LANES];
    logic [NUM_LANES-1:0] w_valid_each;
    logic [NUM_LANES-1:0] w_ack;

    always_comb begin
        w_legal    = (unroll_log2 <= c_uw'(c_log2n));
        w_u_cnt    = c_uw'(1) << unroll_log2;
        w_grp_cnt  = c_uw'(NUM_LANES) >> unroll_log2;
        w_g_mask   = c_log2n'(w_grp_cnt - 1'b1);
        w_mode_chg = (unroll_log2 != r_mode);
        for (int k = 0; k < NUM_LANES; k++) begin
            w_tid[k] = bus.next_tid[k*TID_W +: TID_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= '0;
        end else begin
            r_mode <= unroll_log2;
        end
    end

    for (genvar o = 0; o < NUM_LANES; o++) begin : g_out
        logic [c_log2n-1:0] r_ptr;
        logic [c_aw-1:0]    r_rd;
        logic [c_aw-1:0]    r_wr;
        logic [c_cw-1:0]    r_cnt;
        logic [2*c_ft-1:0]  r_mem [FIFO_DEPTH];

        logic               w_active;
        logic               w_full;
        logic               w_grant;
        logic               w_pop;
        logic [c_log2n-1:0] w_eff_ptr;
        logic [c_log2n-1:0] w_g;
        logic [c_log2n-1:0] w_lane;
        logic [c_log2n-1:0] w_sel_g;
        logic [c_log2n-1:0] w_sel_lane;
        logic [c_ft-1:0]    w_real;
        logic [c_ft-1:0]    w_off;
        logic [c_ft-1:0]    w_cmp;

        always_comb begin
            w_full     = (r_cnt == c_cw'(FIFO_DEPTH));
            w_active   = w_legal && (c_uw'(o) < w_u_cnt) && !flush && !rst;
            w_pop      = bus.out_pop[o] && (r_cnt != '0) && !flush;
            // A pointer left over from a wider group is clamped until the
            // mode-change clear takes effect.
            w_eff_ptr  = (c_uw'(r_ptr) >= w_grp_cnt) ? '0 : r_ptr;
            w_grant    = 1'b0;
            w_sel_g    = '0;
            w_sel_lane = '0;
            w_g        = '0;
            w_lane     = '0;
            if (w_active && !w_full) begin
                // Scan from farthest to nearest so the first valid after the
                // pointer is the last to be written.
                for (int i = NUM_LANES - 1; i >= 0; i--) begin
                    if (c_uw'(i) < w_grp_cnt) begin
                        w_g    = (w_eff_ptr + c_log2n'(i)) & w_g_mask;
                        w_lane = c_log2n'(o) + c_log2n'(w_g << unroll_log2);
                        if (bus.lane_valid[w_lane]) begin
                            w_grant    = 1'b1;
                            w_sel_g    = w_g;
                            w_sel_lane = w_lane;
                        end
                    end
                end
            end
            w_real = {chunk_base_addr, w_tid[w_sel_lane]};
            w_off  = c_ft'(o) * c_ft'(w_grp_cnt) * c_ft'(LANE_STRIDE);
            w_cmp  = w_real - w_off;
        end

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                r_ptr <= '0;
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_mode_chg) begin
                    r_ptr <= '0;
                end else if (w_grant) begin
                    r_ptr <= (w_sel_g + 1'b1) & w_g_mask;
                end
                if (w_grant) begin
                    r_wr <= (r_wr == c_aw'(FIFO_DEPTH - 1)) ? '0 : r_wr + 1'b1;
                end
                if (w_pop) begin
                    r_rd <= (r_rd == c_aw'(FIFO_DEPTH - 1)) ? '0 : r_rd + 1'b1;
                end
                if (w_grant && !w_pop) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (!w_grant && w_pop) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (w_grant && !rst) begin
                r_mem[r_wr] <= {w_cmp, w_real};
            end
        end

        assign w_ack_each[o]   = w_grant ? (NUM_LANES'(1) << w_sel_lane) : '0;
        assign w_valid_each[o] = (r_cnt != '0);
        assign w_cnt_each[o]   = r_cnt;
        assign w_data_each[o]  = (r_cnt != '0) ? r_mem[r_rd] : '0;
    end

    always_comb begin
        w_ack = '0;
        for (int o = 0; o < NUM_LANES; o++) begin
            w_ack = w_ack | w_ack_each[o];
        end
    end

    always_comb begin
        bus.out_data  = '0;
        bus.out_count = '0;
        for (int o = 0; o < NUM_LANES; o++) begin
            bus.out_data[o*2*c_ft +: 2*c_ft] = w_data_each[o];
            bus.out_count[o*c_cw +: c_cw]    = w_cnt_each[o];
        end
    end

    assign bus.lane_ack  = w_ack;
    assign bus.out_valid = w_valid_each;

endmodule
`default_nettype wire
